// File: rtl/forwarding_scoreboard_if.sv
// Decode-to-scoreboard bundle: issue request in, forwarding selects and stall out.
// Purely combinational wiring; no storage.
// Decode side is the master; the scoreboard answers in the same cycle.
interface forwarding_scoreboard_if #(
  parameter int ADDR_W     = 5,
  parameter int NUM_OPS    = 2,
  parameter int FWD_STAGES = 3
);
  localparam int SEL_W = $clog2(FWD_STAGES + 1);

  logic                      advance;
  logic                      flush;
  logic                      issue_valid;
  logic                      issue_regwrite;
  logic                      issue_is_load;
  logic [ADDR_W-1:0]         issue_rd;
  logic [NUM_OPS*ADDR_W-1:0] issue_rs;
  logic [NUM_OPS-1:0]        issue_rs_used;
  logic [NUM_OPS*SEL_W-1:0]  fwd_sel;
  logic                      stall;

  modport master (
    output advance, flush, issue_valid, issue_regwrite, issue_is_load,
           issue_rd, issue_rs, issue_rs_used,
    input  fwd_sel, stall
  );

  modport slave (
    input  advance, flush, issue_valid, issue_regwrite, issue_is_load,
           issue_rd, issue_rs, issue_rs_used,
    output fwd_sel, stall
  );
endinterface

// File: rtl/forwarding_scoreboard.sv
// Purpose: shift-register scoreboard of in-flight dest tags; per-operand forward select and load-use stall.
// Latency: fwd_sel/stall are combinational from registered scoreboard plus current issue inputs (0 cycles).
// Backpressure: stall holds decode; a bubble enters stage 0 on the next advance; advance=0 freezes all entries.
// Optional: define FWDSB_STALL_CNT_EN to add stall_count (16-bit saturating) and stall_count_clr.
module forwarding_scoreboard #(
  parameter int ADDR_W     = 5,
  parameter int NUM_OPS    = 2,
  parameter int FWD_STAGES = 3,
  parameter int LOAD_READY = 1
) (
  input  logic                   clk,
  input  logic                   arst_n,
  forwarding_scoreboard_if.slave bus,
  output logic [FWD_STAGES-1:0]  stage_valid
`ifdef FWDSB_STALL_CNT_EN
  ,
  input  logic                   stall_count_clr,
  output logic [15:0]            stall_count
`endif
);
  localparam int SEL_W = $clog2(FWD_STAGES + 1);

  // Scoreboard entries, index 0 is the youngest (EX) stage.
  logic [FWD_STAGES-1:0] valid_q;
  logic [FWD_STAGES-1:0] ld_q;
  logic [ADDR_W-1:0]     rd_q [FWD_STAGES];

  // Candidate entry for stage 0 on the next advance.
  logic              ins_valid;
  logic              ins_ld;
  logic [ADDR_W-1:0] ins_rd;

  // Lookup results.
  logic [NUM_OPS-1:0]       unready;
  logic [NUM_OPS*SEL_W-1:0] sel_packed;
  logic                     stall_int;
  logic                     found;
  logic [ADDR_W-1:0]        rs_cur;

  // Per operand, the youngest matching stage alone decides: either forward from it
  // or, if it is a load that has not reached LOAD_READY yet, mark the operand unready.
  always_comb begin
    unready    = '0;
    sel_packed = '0;
    found      = 1'b0;
    rs_cur     = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      found  = 1'b0;
      rs_cur = bus.issue_rs[i*ADDR_W +: ADDR_W];
      for (int k = 0; k < FWD_STAGES; k++) begin
        if (!found && bus.issue_rs_used[i] && (rs_cur != '0) &&
            valid_q[k] && (rd_q[k] == rs_cur)) begin
          found = 1'b1;
          if (ld_q[k] && (k < LOAD_READY)) begin
            unready[i] = 1'b1;
          end else begin
            sel_packed[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
          end
        end
      end
    end
  end

  assign stall_int   = bus.issue_valid && (|unready);
  assign bus.stall   = stall_int;
  assign bus.fwd_sel = sel_packed;
  assign stage_valid = valid_q;

  // Build the stage-0 entry; flush or stall turn it into a bubble, x0 is never tracked.
  always_comb begin
    ins_valid = 1'b0;
    ins_ld    = 1'b0;
    ins_rd    = '0;
    if (!bus.flush && !stall_int && bus.issue_valid &&
        bus.issue_regwrite && (bus.issue_rd != '0)) begin
      ins_valid = 1'b1;
      ins_ld    = bus.issue_is_load;
      ins_rd    = bus.issue_rd;
    end
  end

  // Shift the scoreboard one stage older on each advance; the oldest entry falls off.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      valid_q <= '0;
      ld_q    <= '0;
      for (int k = 0; k < FWD_STAGES; k++) begin
        rd_q[k] <= '0;
      end
    end else if (bus.advance) begin
      valid_q <= {valid_q[FWD_STAGES-2:0], ins_valid};
      ld_q    <= {ld_q[FWD_STAGES-2:0], ins_ld};
      rd_q[0] <= ins_rd;
      for (int k = 1; k < FWD_STAGES; k++) begin
        rd_q[k] <= rd_q[k-1];
      end
    end
  end

`ifdef FWDSB_STALL_CNT_EN
  // Count cycles where a bubble is actually inserted; clear wins, saturate at all-ones.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_count <= '0;
    end else if (stall_count_clr) begin
      stall_count <= '0;
    end else if (stall_int && bus.advance && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule
